// File: rtl/fp_misc_pkg.sv
// Shared types and constants for the FP misc issue controller.
// Optional build macro used by the top: FP_MISC_PERF_EN (perf counters).
package fp_misc_pkg;

  localparam int FP_MISC_TAG_W = 5;

  // Packed op width as a function of the tag width
  function automatic int fp_misc_op_w(input int tag_w);
    return 141 + tag_w;
  endfunction

  // Packed op layout as carried by the issue slots
  typedef struct packed {
    logic [64:0]              rs1;
    logic [64:0]              rs2;
    logic [2:0]               rm;
    logic                     fp64;
    logic [5:0]               ctrl;
    logic                     lt;
    logic [FP_MISC_TAG_W-1:0] tag;
  } fp_misc_op_t;

  // One-hot ctrl bit positions
  localparam int FMIN_BIT   = 5;
  localparam int FMAX_BIT   = 4;
  localparam int FSGNJ_BIT  = 3;
  localparam int FSGNJN_BIT = 2;
  localparam int FSGNJX_BIT = 1;
  localparam int FCVT_BIT   = 0;

  // Recoded canonical NaNs, produced by the datapath
  localparam logic [32:0] CANON_NAN_S = 33'h0_e040_0000;
  localparam logic [64:0] CANON_NAN_D = 65'h0_e008_0000_0000_0000;

endpackage

// File: rtl/fp_misc_issue_ctrl_slice.sv
// fp_misc_slice: generic valid/ready register slice with flush.
// Accepts whenever empty or the downstream consumer takes the current entry.
module fp_misc_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         v_q;
  logic         v_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  assign in_ready  = !v_q | out_ready;
  assign out_valid = v_q;
  assign out_data  = data_q;

  // Next entry: flush empties the slice, otherwise load when there is room
  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    if (flush) begin
      v_d = 1'b0;
    end else if (in_ready) begin
      v_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end else begin
        data_d = data_q;
      end
    end else begin
      v_d = v_q;
    end
  end

  // Slice register
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/fp_misc_issue_ctrl.sv
// fp_misc_issue_ctrl: sequences the shared FP misc datapath between issue
// slots i0 (older) and i1 (younger). H parks i1 on a dual accept, S1 drives
// the datapath, S2 (fp_misc_slice) holds results for writeback.
// Optional build macro: FP_MISC_PERF_EN adds perf_ops / perf_stall counters.
module fp_misc_issue_ctrl
  import fp_misc_pkg::*;
#(
  parameter int TAG_W = 5,
  parameter int OP_W  = fp_misc_op_w(TAG_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  i0_valid,
  output logic                  i0_ready,
  input  logic [OP_W-1:0]       i0_op,
  input  logic                  i1_valid,
  output logic                  i1_ready,
  input  logic [OP_W-1:0]       i1_op,
  output logic [OP_W-TAG_W-1:0] dp_op,
  input  logic [64:0]           dp_data,
  input  logic [4:0]            dp_exc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [64:0]           out_data,
  output logic [4:0]            out_exc,
  output logic [TAG_W-1:0]      out_tag
`ifdef FP_MISC_PERF_EN
  ,
  output logic [31:0]           perf_ops,
  output logic [31:0]           perf_stall
`endif
);

  localparam int S2_W = 65 + 5 + TAG_W;

  logic            h_v_q;
  logic            h_v_d;
  logic [OP_W-1:0] h_op_q;
  logic [OP_W-1:0] h_op_d;
  logic            s1_v_q;
  logic            s1_v_d;
  logic [OP_W-1:0] s1_op_q;
  logic [OP_W-1:0] s1_op_d;

  logic            s2_free;
  logic            s1_en;
  logic            slot_rdy;
  logic            i0_acc;
  logic            i1_acc;
  logic [S2_W-1:0] s2_in;
  logic [S2_W-1:0] s2_out;

  // Both slots share one readiness so i1 can never overtake a stalled i0
  assign s1_en    = !s1_v_q | s2_free;
  assign slot_rdy = s1_en & !h_v_q & !flush & !rst;
  assign i0_ready = slot_rdy;
  assign i1_ready = slot_rdy;
  assign i0_acc   = i0_valid & slot_rdy;
  assign i1_acc   = i1_valid & slot_rdy;

  assign dp_op = s1_op_q[OP_W-1:TAG_W];
  assign s2_in = {dp_data, dp_exc, s1_op_q[TAG_W-1:0]};

  // S1/H next state: flush wins, then H drains first, then i0, then i1
  always_comb begin
    h_v_d   = h_v_q;
    h_op_d  = h_op_q;
    s1_v_d  = s1_v_q;
    s1_op_d = s1_op_q;
    if (flush) begin
      h_v_d  = 1'b0;
      s1_v_d = 1'b0;
    end else if (s1_en) begin
      if (h_v_q) begin
        s1_v_d  = 1'b1;
        s1_op_d = h_op_q;
        h_v_d   = 1'b0;
      end else if (i0_acc) begin
        s1_v_d  = 1'b1;
        s1_op_d = i0_op;
        if (i1_acc) begin
          h_v_d  = 1'b1;
          h_op_d = i1_op;
        end else begin
          h_v_d = 1'b0;
        end
      end else if (i1_acc) begin
        s1_v_d  = 1'b1;
        s1_op_d = i1_op;
      end else begin
        s1_v_d = 1'b0;
      end
    end else begin
      s1_v_d = s1_v_q;
    end
  end

  // Hold and operand registers
  always_ff @(posedge clk) begin
    if (rst) begin
      h_v_q   <= 1'b0;
      h_op_q  <= '0;
      s1_v_q  <= 1'b0;
      s1_op_q <= '0;
    end else begin
      h_v_q   <= h_v_d;
      h_op_q  <= h_op_d;
      s1_v_q  <= s1_v_d;
      s1_op_q <= s1_op_d;
    end
  end

  fp_misc_slice #(.W(S2_W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (s1_v_q),
    .in_ready  (s2_free),
    .in_data   (s2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_out)
  );

  assign out_data = s2_out[S2_W-1 -: 65];
  assign out_exc  = s2_out[TAG_W +: 5];
  assign out_tag  = s2_out[TAG_W-1:0];

`ifdef FP_MISC_PERF_EN
  logic [31:0] perf_ops_q;
  logic [31:0] perf_ops_d;
  logic [31:0] perf_stall_q;
  logic [31:0] perf_stall_d;

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;

  // Saturating completion and blocked-request counters, flush-insensitive
  always_comb begin
    perf_ops_d   = perf_ops_q;
    perf_stall_d = perf_stall_q;
    if (out_valid && out_ready && (perf_ops_q != 32'hFFFF_FFFF)) begin
      perf_ops_d = perf_ops_q + 32'd1;
    end else begin
      perf_ops_d = perf_ops_q;
    end
    if ((i0_valid || i1_valid) && !i0_ready && !flush &&
        (perf_stall_q != 32'hFFFF_FFFF)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end else begin
      perf_stall_d = perf_stall_q;
    end
  end

  // Perf counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops_q   <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      perf_ops_q   <= perf_ops_d;
      perf_stall_q <= perf_stall_d;
    end
  end
`endif

endmodule

// File: tb/tb_fp_misc_issue_ctrl.sv
// Directed self-checking bench for fp_misc_issue_ctrl. A stand-in datapath
// derives result and flags from the registered operands so that routing of
// operands, flags and tags is visible at the outputs.
module tb_fp_misc_issue_ctrl;
  import fp_misc_pkg::*;

  localparam int TW = 5;
  localparam int OW = fp_misc_op_w(TW);
  localparam int DW = OW - TW;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          i0_valid;
  logic          i0_ready;
  logic [OW-1:0] i0_op;
  logic          i1_valid;
  logic          i1_ready;
  logic [OW-1:0] i1_op;
  logic [DW-1:0] dp_op;
  logic [64:0]   dp_data;
  logic [4:0]    dp_exc;
  logic          out_valid;
  logic          out_ready;
  logic [64:0]   out_data;
  logic [4:0]    out_exc;
  logic [TW-1:0] out_tag;
`ifdef FP_MISC_PERF_EN
  logic [31:0]   perf_ops;
  logic [31:0]   perf_stall;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fp_misc_issue_ctrl #(.TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .i0_valid(i0_valid), .i0_ready(i0_ready), .i0_op(i0_op),
    .i1_valid(i1_valid), .i1_ready(i1_ready), .i1_op(i1_op),
    .dp_op(dp_op), .dp_data(dp_data), .dp_exc(dp_exc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_exc(out_exc), .out_tag(out_tag)
`ifdef FP_MISC_PERF_EN
    , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Build a distinctive op from a small id
  function automatic fp_misc_op_t mk(input int t);
    fp_misc_op_t o;
    logic [7:0] b;
    b      = t[7:0];
    o.rs1  = {1'b0, 56'h12_3456_789a_bcde, b};
    o.rs2  = {1'b1, ~b, 56'h0f_0e0d_0c0b_0a09};
    o.rm   = b[2:0];
    o.fp64 = b[0];
    o.ctrl = 6'b01_0000;
    o.lt   = b[1];
    o.tag  = b[4:0];
    return o;
  endfunction

  function automatic logic [64:0] exp_data(input fp_misc_op_t o);
    return o.rs1 ^ {o.rs2[63:0], o.rs2[64]};
  endfunction

  function automatic logic [4:0] exp_exc(input fp_misc_op_t o);
    return {o.rm, o.lt, o.fp64};
  endfunction

  // Stand-in combinational datapath
  fp_misc_op_t dp_s;
  always_comb begin
    dp_s    = {dp_op, {TW{1'b0}}};
    dp_data = exp_data(dp_s);
    dp_exc  = exp_exc(dp_s);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i0_valid = 1'b0;
    i1_valid = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fp_misc_op_t o;
    logic [127:0] snap;
    bit have_snap;
    bit saw_low;
    int issued;
    int recvd;
    int spur;

    // ---------------- reset state
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    i0_valid = 1'b1; i1_valid = 1'b1; i0_op = mk(3); i1_op = mk(2);
    tick(); tick(); tick();
    chk("rst_i0_ready", i0_ready, 0);
    chk("rst_i1_ready", i1_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_exc", out_exc, 0);
    chk("rst_dp_op", dp_op, 0);

    // ---------------- single i0 op, tag 3
    rst = 1'b0; idle(); tick();
    i0_valid = 1'b1; i0_op = mk(3);
    #1 chk("one_ready", i0_ready, 1);
    tick();
    idle();
    o = mk(3);
    #1 chk("one_lat1_valid", out_valid, 0);
    chk("one_dp_op", dp_op, o[OW-1:TW]);
    tick();
    chk("one_valid", out_valid, 1);
    chk("one_tag", out_tag, 3);
    chk("one_data", out_data, exp_data(o));
    chk("one_exc", out_exc, exp_exc(o));
    tick();
    chk("one_drained", out_valid, 0);

    // ---------------- dual issue, tags 1 and 2
    i0_valid = 1'b1; i0_op = mk(1); i1_valid = 1'b1; i1_op = mk(2);
    #1 chk("dual_i0_ready", i0_ready, 1);
    chk("dual_i1_ready", i1_ready, 1);
    tick();
    #1 chk("dual_h_full_ready", i0_ready, 0);
    chk("dual_c1_valid", out_valid, 0);
    idle();
    tick();
    chk("dual_first", {out_valid, out_tag}, {1'b1, 5'd1});
    chk("dual_first_data", out_data, exp_data(mk(1)));
    tick();
    chk("dual_second", {out_valid, out_tag}, {1'b1, 5'd2});
    chk("dual_second_exc", out_exc, exp_exc(mk(2)));
    tick();
    chk("dual_drained", out_valid, 0);

    // ---------------- back-pressure, tags 4..7
    issued = 0; recvd = 0; saw_low = 1'b0; have_snap = 1'b0; snap = '0;
    for (int c = 0; c < 40 && recvd < 4; c++) begin
      out_ready = !(c >= 2 && c <= 4);
      i0_valid  = (issued < 4);
      i0_op     = mk(4 + issued);
      #1;
      if (have_snap) chk("bp_hold", {out_valid, out_tag, out_exc, out_data}, snap);
      have_snap = out_valid && !out_ready;
      snap = {out_valid, out_tag, out_exc, out_data};
      if (i0_valid && !i0_ready) saw_low = 1'b1;
      if (out_valid && out_ready) begin
        chk("bp_tag", out_tag, 4 + recvd);
        chk("bp_data", out_data, exp_data(mk(4 + recvd)));
        recvd++;
      end
      if (i0_valid && i0_ready) issued++;
      tick();
    end
    chk("bp_count", recvd, 4);
    chk("bp_ready_drop", saw_low, 1);
    idle(); out_ready = 1'b1; tick(); tick();

    // ---------------- flush with H, S1, S2 all valid
    out_ready = 1'b0;
    i0_valid = 1'b1; i0_op = mk(8);
    tick();
    idle();
    tick();
    i0_valid = 1'b1; i0_op = mk(10); i1_valid = 1'b1; i1_op = mk(11);
    #1 chk("fl_dual_ready", i1_ready, 1);
    tick();
    idle();
    #1 chk("fl_pre_valid", out_valid, 1);
    flush = 1'b1; i0_valid = 1'b1; i0_op = mk(13);
    #1 chk("fl_ready_low", i0_ready, 0);
    tick();
    flush = 1'b0; i0_valid = 1'b1; i0_op = mk(12);
    #1 chk("fl_cleared", out_valid, 0);
    chk("fl_new_ready", i0_ready, 1);
    tick();
    idle(); out_ready = 1'b1;
    #1 chk("fl_new_lat1", out_valid, 0);
    tick();
    chk("fl_new_out", {out_valid, out_tag}, {1'b1, 5'd12});
    tick();
    spur = 0;
    for (int k = 0; k < 5; k++) begin
      if (out_valid) spur++;
      tick();
    end
    chk("fl_no_stale", spur, 0);

    // ---------------- reset mid-stream
    out_ready = 1'b0;
    i0_valid = 1'b1; i0_op = mk(14);
    tick();
    i0_op = mk(15);
    tick();
    idle();
    #1 chk("rs_pre_valid", out_valid, 1);
    rst = 1'b1; i0_valid = 1'b1;
    #1 chk("rs_i0_ready", i0_ready, 0);
    chk("rs_i1_ready", i1_ready, 0);
    tick();
    chk("rs_out_valid", out_valid, 0);
    chk("rs_out_data", out_data, 0);
    chk("rs_out_exc", out_exc, 0);
    chk("rs_out_tag", out_tag, 0);
    chk("rs_dp_op", dp_op, 0);
    rst = 1'b0; idle(); out_ready = 1'b1;
    spur = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (out_valid) spur++;
    end
    chk("rs_no_output", spur, 0);

`ifdef FP_MISC_PERF_EN
    // ---------------- perf counters: 3 completions, 2 blocked cycles
    idle(); rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b0;
    i0_valid = 1'b1; i0_op = mk(20);
    tick();
    idle();
    tick();
    i0_valid = 1'b1; i0_op = mk(21);
    tick();
    i0_op = mk(22);
    tick();
    tick();
    out_ready = 1'b1;
    tick();
    idle();
    tick(); tick(); tick(); tick();
    chk("perf_ops", perf_ops, 3);
    chk("perf_stall", perf_stall, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
